timer_countdown: RTL and testbench

- Downstream of the keypad/input control stage; the sole consumer of its BCD digit, load strobe and 1 Hz tick.
- Shift-loads keyed digits into a three-digit M:SS register and counts down at 1 Hz while cooking is enabled.
- Flags zero time and reports completion to the microwave top-level controller.
- Digit outputs drive the display decoders.

---
 rtl/timer_countdown.sv | 149 ++++++++++++++
 tb/tb_timer_countdown.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// Three-digit M:SS countdown timer: shift-loads keyed BCD digits, counts down at 1 Hz
// while enabled, flags zero time and pulses done when a countdown reaches 0:00.
module timer_countdown #(
    parameter int unsigned SEC_TENS_WRAP = 5,
    parameter int unsigned SEC_ONES_WRAP = 9
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] BCD,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       en,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done
);

    localparam int unsigned DW = 4;
    localparam logic [DW-1:0] TENS_WRAP = DW'(SEC_TENS_WRAP);
    localparam logic [DW-1:0] ONES_WRAP = DW'(SEC_ONES_WRAP);
    localparam logic [DW-1:0] MAX_DIGIT = DW'(9);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_mins;
    logic [DW-1:0] r_sec_tens;
    logic [DW-1:0] r_sec_ones;
    logic          r_zero;
    logic          r_done;
    logic          r_loadn_d;
    logic          r_tick_d;

    state_t        w_state_nxt;
    logic [DW-1:0] w_mins_nxt;
    logic [DW-1:0] w_tens_nxt;
    logic [DW-1:0] w_ones_nxt;
    logic          w_done_nxt;
    logic          w_zero_nxt;
    logic          w_load_ev;
    logic          w_tick_ev;
    logic          w_digit_ok;
    logic [DW-1:0] w_dec_mins;
    logic [DW-1:0] w_dec_tens;
    logic [DW-1:0] w_dec_ones;
    logic          w_dec_zero;

    assign w_load_ev  = r_loadn_d & ~loadn;
    assign w_tick_ev  = ~r_tick_d & pgt_1Hz;
    assign w_digit_ok = (BCD <= MAX_DIGIT);

    // One BCD decrement with cascaded borrows, ones -> tens -> mins.
    always_comb begin
        w_dec_mins = r_mins;
        w_dec_tens = r_sec_tens;
        w_dec_ones = r_sec_ones;
        if (r_sec_ones != '0) begin
            w_dec_ones = r_sec_ones - DW'(1);
        end else begin
            w_dec_ones = ONES_WRAP;
            if (r_sec_tens != '0) begin
                w_dec_tens = r_sec_tens - DW'(1);
            end else begin
                w_dec_tens = TENS_WRAP;
                w_dec_mins = r_mins - DW'(1);
            end
        end
        w_dec_zero = ((w_dec_mins | w_dec_tens | w_dec_ones) == '0);
    end

    // Next-state and next-digit logic.
    always_comb begin
        w_state_nxt = r_state;
        w_mins_nxt  = r_mins;
        w_tens_nxt  = r_sec_tens;
        w_ones_nxt  = r_sec_ones;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            ST_ENTRY: begin
                if (w_load_ev && w_digit_ok) begin
                    w_mins_nxt = r_sec_tens;
                    w_tens_nxt = r_sec_ones;
                    w_ones_nxt = BCD;
                end
                if (en && !r_zero) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_ENTRY;
                end else if (w_tick_ev && !r_zero) begin
                    // A tick on an already-empty timer must never wrap to 9:59.
                    w_mins_nxt = w_dec_mins;
                    w_tens_nxt = w_dec_tens;
                    w_ones_nxt = w_dec_ones;
                    if (w_dec_zero) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!en) begin
                    w_state_nxt = ST_ENTRY;
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
        w_zero_nxt = ((w_mins_nxt | w_tens_nxt | w_ones_nxt) == '0);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= ST_ENTRY;
            r_mins     <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_zero     <= 1'b1;
            r_done     <= 1'b0;
            r_loadn_d  <= 1'b1;
            r_tick_d   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mins     <= w_mins_nxt;
            r_sec_tens <= w_tens_nxt;
            r_sec_ones <= w_ones_nxt;
            r_zero     <= w_zero_nxt;
            r_done     <= w_done_nxt;
            r_loadn_d  <= loadn;
            r_tick_d   <= pgt_1Hz;
        end
    end

    assign mins     = r_mins;
    assign sec_tens = r_sec_tens;
    assign sec_ones = r_sec_ones;
    assign zero     = r_zero;
    assign done     = r_done;

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: cycle-by-cycle comparison against a digit-level timer model,
// plus literal checkpoints taken straight from the test plan.
module tb_timer_countdown;

    logic       clock;
    logic       clear;
    logic [3:0] BCD;
    logic       loadn;
    logic       pgt_1Hz;
    logic       en;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       zero;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit cmp_en   = 1'b0;

    timer_countdown #(.SEC_TENS_WRAP(5), .SEC_ONES_WRAP(9)) dut (
        .clock    (clock),
        .clear    (clear),
        .BCD      (BCD),
        .loadn    (loadn),
        .pgt_1Hz  (pgt_1Hz),
        .en       (en),
        .mins     (mins),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .zero     (zero),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: digits held as an array d[2]=mins, d[1]=tens, d[0]=ones; mode 0 entry, 1 counting, 2 finished.
    int  md[3];
    int  m_mode;
    bit  m_done;
    bit  m_loadn_d;
    bit  m_tick_d;

    function automatic bit is_empty(input int a2, input int a1, input int a0);
        return (a2 + a1 + a0) == 0;
    endfunction

    always @(posedge clock) begin
        int  d[3];
        bit  lev, tev, pulse;
        int  mode;
        d = md;
        mode = m_mode;
        pulse = 1'b0;
        if (clear) begin
            d = '{0, 0, 0};
            mode = 0;
            m_loadn_d <= 1'b1;
            m_tick_d  <= 1'b0;
        end else begin
            lev = m_loadn_d && !loadn;
            tev = !m_tick_d && pgt_1Hz;
            if (mode == 0) begin
                if (lev && int'(BCD) <= 9) begin
                    d[2] = md[1];
                    d[1] = md[0];
                    d[0] = int'(BCD);
                end
                if (en && !is_empty(md[2], md[1], md[0])) mode = 1;
            end else if (mode == 1) begin
                if (!en) mode = 0;
                else if (tev && !is_empty(md[2], md[1], md[0])) begin
                    // Take one second off: borrow 1 minute as 60 seconds when the seconds run out.
                    if (d[1] * 10 + d[0] > 0) begin
                        if (d[0] > 0) d[0] = d[0] - 1;
                        else begin d[1] = d[1] - 1; d[0] = 9; end
                    end else begin
                        d[2] = d[2] - 1; d[1] = 5; d[0] = 9;
                    end
                    if (is_empty(d[2], d[1], d[0])) begin
                        mode = 2;
                        pulse = 1'b1;
                    end
                end
            end else begin
                if (!en) mode = 0;
            end
            m_loadn_d <= loadn;
            m_tick_d  <= pgt_1Hz;
        end
        md     <= d;
        m_mode <= mode;
        m_done <= pulse;
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("mins",     int'(mins),     md[2]);
            check("sec_tens", int'(sec_tens), md[1]);
            check("sec_ones", int'(sec_ones), md[0]);
            check("zero",     int'(zero),     int'(is_empty(md[2], md[1], md[0])));
            check("done",     int'(done),     int'(m_done));
            if (done) done_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_clear();
        @(negedge clock); clear = 1'b1; en = 1'b0;
        @(negedge clock); clear = 1'b0;
    endtask

    task automatic key(input logic [3:0] v);
        @(negedge clock); BCD = v; loadn = 1'b0;
        @(negedge clock); loadn = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock); pgt_1Hz = 1'b1;
            @(negedge clock); pgt_1Hz = 1'b0;
        end
    endtask

    task automatic expect_time(input string name, input int m, input int t, input int o);
        @(posedge clock); #2;
        check({name, ".mins"}, int'(mins), m);
        check({name, ".tens"}, int'(sec_tens), t);
        check({name, ".ones"}, int'(sec_ones), o);
    endtask

    int done_start;

    initial begin
        clear = 1'b1; BCD = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0; en = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock); clear = 1'b0; cmp_en = 1'b1;
        expect_time("reset", 0, 0, 0);
        check("reset.zero", int'(zero), 1);
        check("reset.done", int'(done), 0);

        // Digit entry and held-key single shift
        key(4'd1); key(4'd3); key(4'd0);
        expect_time("load130", 1, 3, 0);
        check("load130.zero", int'(zero), 0);
        @(negedge clock); BCD = 4'd7; loadn = 1'b0;
        idle(10); loadn = 1'b1;
        expect_time("held7", 3, 0, 7);

        // 0:05 countdown to done
        do_clear(); key(4'd0); key(4'd5);
        @(negedge clock); en = 1'b1; idle(1);
        done_start = done_cnt;
        tick(4);
        expect_time("cnt4", 0, 0, 1);
        tick(1);
        expect_time("cnt5", 0, 0, 0);
        check("cnt5.zero", int'(zero), 1);
        tick(3);
        expect_time("past0", 0, 0, 0);
        check("done_pulses", done_cnt - done_start, 1);

        // Borrows and unranged digits
        do_clear(); key(4'd1); key(4'd0); key(4'd0);
        @(negedge clock); en = 1'b1; idle(1); tick(1);
        expect_time("borrow100", 0, 5, 9);
        do_clear(); key(4'd9); key(4'd9);
        @(negedge clock); en = 1'b1; idle(1); tick(1);
        expect_time("dec099", 0, 9, 8);
        do_clear(); key(4'd9); key(4'd0);
        @(negedge clock); en = 1'b1; idle(1); tick(10);
        expect_time("dec090x10", 0, 8, 0);

        // Pause, load while paused, resume
        do_clear(); key(4'd3); key(4'd0);
        @(negedge clock); en = 1'b1; idle(1); tick(3);
        expect_time("run27", 0, 2, 7);
        @(negedge clock); en = 1'b0; idle(1); tick(2);
        expect_time("paused", 0, 2, 7);
        key(4'd4);
        expect_time("pause_load", 2, 7, 4);
        @(negedge clock); en = 1'b1; idle(1); tick(1);
        expect_time("resume", 2, 7, 3);

        // Invalid code ignored; enable at 0:00 never pulses
        do_clear(); key(4'd5); key(4'd12);
        expect_time("bcd12", 0, 0, 5);
        do_clear(); done_start = done_cnt;
        @(negedge clock); en = 1'b1; idle(1); tick(3);
        expect_time("en_at_zero", 0, 0, 0);
        check("en_at_zero.done", done_cnt - done_start, 0);

        // Clear during a countdown
        do_clear(); key(4'd1); key(4'd0);
        @(negedge clock); en = 1'b1; idle(1); tick(2);
        expect_time("pre_clear", 0, 0, 8);
        @(negedge clock); clear = 1'b1;
        @(negedge clock); clear = 1'b0;
        expect_time("post_clear", 0, 0, 0);
        check("post_clear.zero", int'(zero), 1);
        check("post_clear.done", int'(done), 0);
        tick(1);
        expect_time("post_clear_tick", 0, 0, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
